tau_synth: RTL and testbench

Period-driven tone synthesizer: the output side of the pitch-tracking path, consuming period estimates (in samples) of the same form the YIN detector emits and producing a sample stream of that period. Each accepted period is converted by an internal sequential divider into a phase step. A phase accumulator is advanced once per sample tick. Period changes take effect only at a waveform cycle boundary, so output is glitch-free.

---
 rtl/tau_synth.sv | 254 +++++++++++++++++++++++++
 tb/tb_tau_synth.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tau_synth.sv
`default_nettype none
// ============================================================================
// Module   : tau_synth
// Purpose  : Period-driven tone synthesizer. A sequential restoring divider
//            converts each requested period into a phase step. A phase
//            accumulator then produces a sawtooth, or a triangle when
//            TAU_SYNTH_TRIANGLE_EN is defined. Period changes and mutes take
//            effect only at a waveform cycle boundary.
// Revision : 1.0 - initial release
// ============================================================================
module tau_synth #(
    parameter int WIDTH  = 16,
    parameter int TAUMAX = 2048,
    parameter int FRAC   = 10
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [$clog2(TAUMAX)-1:0] period_in,
    input  logic                      period_valid_in,
    input  logic                      sample_tick_in,
    output logic [WIDTH-1:0]          sample_out,
    output logic                      valid_out,
    output logic                      active_out,
    output logic                      busy_out
);

    localparam int PW = $clog2(TAUMAX);
    localparam int A  = WIDTH + FRAC;
    localparam int CW = $clog2(A);

    localparam logic [WIDTH-1:0] MIDSCALE   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PW-1:0]    MIN_PERIOD = PW'(2);
    localparam logic [CW-1:0]    LAST_ITER  = CW'(A - 1);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_BUSY = 2'd1,
        D_DONE = 2'd2
    } div_state_t;

    div_state_t        r_div_state;
    div_state_t        w_div_next;

    // Oscillator state
    logic [PW-1:0]     r_cur_period;
    logic [A-1:0]      r_cur_step;
    logic [PW-1:0]     r_count;
    logic [A-1:0]      r_acc;
    logic              r_active;

    // Pending request state
    logic [PW-1:0]     r_pend_period;
    logic [A-1:0]      r_pend_step;
    logic              r_pend_ready;
    logic              r_pend_mute;

    // Divider working registers
    logic [PW-1:0]     r_rem;
    logic [A-1:0]      r_quot;
    logic [CW-1:0]     r_iter;

    // Output registers
    logic [WIDTH-1:0]  r_sample;
    logic              r_valid;

    logic              w_req_short;
    logic              w_mute_req;
    logic              w_ignore;
    logic              w_start;
    logic [PW:0]       w_rem_shift;
    logic [PW:0]       w_rem_sub;
    logic              w_quot_bit;
    logic [PW-1:0]     w_rem_next;
    logic              w_boundary;
    logic              w_ready_now;
    logic [A-1:0]      w_step_now;
    logic              w_swap;
    logic [WIDTH-1:0]  w_phase;
    logic [WIDTH-1:0]  w_shaped;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_req_short = (period_in < MIN_PERIOD);
    assign w_mute_req  = period_valid_in && w_req_short;
    assign w_ignore    = r_active && (period_in == r_cur_period) && !r_pend_ready &&
                         !r_pend_mute && (r_div_state == D_IDLE);
    assign w_start     = period_valid_in && !w_req_short && !w_ignore;

    // ------------------------------------------------------------------
    // Restoring divider step: the sign of the trial subtraction is the
    // quotient bit (remainder is always below the divisor).
    // ------------------------------------------------------------------
    assign w_rem_shift = {r_rem, 1'b0};
    assign w_rem_sub   = w_rem_shift - {1'b0, r_pend_period};
    assign w_quot_bit  = ~w_rem_sub[PW];
    assign w_rem_next  = w_quot_bit ? w_rem_sub[PW-1:0] : w_rem_shift[PW-1:0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_div_state <= D_IDLE;
        end else begin
            r_div_state <= w_div_next;
        end
    end

    always_comb begin
        w_div_next = r_div_state;
        case (r_div_state)
            D_IDLE: begin
                if (w_start) begin
                    w_div_next = D_BUSY;
                end
            end
            D_BUSY: begin
                if (w_mute_req) begin
                    w_div_next = D_IDLE;
                end else if (w_start) begin
                    w_div_next = D_BUSY;
                end else if (r_iter == LAST_ITER) begin
                    w_div_next = D_DONE;
                end
            end
            D_DONE: begin
                w_div_next = w_start ? D_BUSY : D_IDLE;
            end
            default: begin
                w_div_next = D_IDLE;
            end
        endcase
    end

    // The leading dividend bit (2^A) is preloaded as remainder 1, which is
    // always below a legal divisor, so A further iterations suffice.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_iter <= '0;
        end else if (w_start) begin
            r_rem  <= PW'(1);
            r_quot <= '0;
            r_iter <= '0;
        end else if (r_div_state == D_BUSY) begin
            r_rem  <= w_rem_next;
            r_quot <= {r_quot[A-2:0], w_quot_bit};
            r_iter <= r_iter + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Waveform shaping
    // ------------------------------------------------------------------
    assign w_phase = r_acc[A-1 -: WIDTH];

`ifdef TAU_SYNTH_TRIANGLE_EN
    always_comb begin
        w_shaped = {w_phase[WIDTH-2:0], 1'b0};
        if (w_phase[WIDTH-1]) begin
            w_shaped = ~{w_phase[WIDTH-2:0], 1'b0};
        end
    end
`else
    always_comb begin
        w_shaped = w_phase;
    end
`endif

    // ------------------------------------------------------------------
    // Oscillator, pending-state application and request capture
    // ------------------------------------------------------------------
    assign w_boundary  = sample_tick_in && r_active &&
                         (r_count == (r_cur_period - PW'(1)));
    // A divider finishing on a boundary tick hands its result straight over.
    assign w_ready_now = r_pend_ready || (r_div_state == D_DONE);
    assign w_step_now  = (r_div_state == D_DONE) ? r_quot : r_pend_step;
    assign w_swap      = w_boundary && !r_pend_mute && w_ready_now;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cur_period  <= '0;
            r_cur_step    <= '0;
            r_count       <= '0;
            r_acc         <= '0;
            r_active      <= 1'b0;
            r_pend_period <= '0;
            r_pend_step   <= '0;
            r_pend_ready  <= 1'b0;
            r_pend_mute   <= 1'b0;
            r_sample      <= MIDSCALE;
            r_valid       <= 1'b0;
        end else begin
            r_valid <= sample_tick_in;
            if (sample_tick_in) begin
                r_sample <= r_active ? w_shaped : MIDSCALE;
            end

            if (r_active) begin
                if (sample_tick_in) begin
                    if (w_boundary) begin
                        r_count <= '0;
                        r_acc   <= '0;
                        if (r_pend_mute) begin
                            r_active    <= 1'b0;
                            r_pend_mute <= 1'b0;
                        end else if (w_ready_now) begin
                            r_cur_period <= r_pend_period;
                            r_cur_step   <= w_step_now;
                            r_pend_ready <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + PW'(1);
                        r_acc   <= r_acc + r_cur_step;
                    end
                end
            end else begin
                r_pend_mute <= 1'b0;
                if (r_pend_ready) begin
                    r_active     <= 1'b1;
                    r_count      <= '0;
                    r_acc        <= '0;
                    r_cur_period <= r_pend_period;
                    r_cur_step   <= r_pend_step;
                    r_pend_ready <= 1'b0;
                end
            end

            if ((r_div_state == D_DONE) && !w_swap) begin
                r_pend_step  <= r_quot;
                r_pend_ready <= 1'b1;
            end

            // Requests come last so they override the pending state above,
            // while this cycle's tick has already used the pre-request state.
            if (period_valid_in) begin
                if (w_req_short) begin
                    r_pend_mute  <= 1'b1;
                    r_pend_ready <= 1'b0;
                end else if (!w_ignore) begin
                    r_pend_period <= period_in;
                    r_pend_mute   <= 1'b0;
                    r_pend_ready  <= 1'b0;
                end
            end
        end
    end

    assign sample_out = r_sample;
    assign valid_out  = r_valid;
    assign active_out = r_active;
    assign busy_out   = (r_div_state != D_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tau_synth.sv
`default_nettype none
// Testbench for tau_synth: randomized and directed period requests checked
// against a phase-index reference model of the synthesizer.
module tb_tau_synth;

    localparam int W   = 16;
    localparam int FR  = 10;
    localparam int AW  = W + FR;
    localparam int PWB = 11;
    localparam int MID = 32768;

    logic           clk;
    logic           rst;
    logic [PWB-1:0] period;
    logic           period_valid;
    logic           tick;
    logic [W-1:0]   sample;
    logic           valid;
    logic           active;
    logic           busy;

    int checks;
    int errors;

    // Reference model: phase index k within a cycle of m_per samples
    bit m_active;
    int m_per;
    int m_k;
    bit m_pend;
    int m_pend_per;
    bit m_mute;

    tau_synth #(.WIDTH(W), .TAUMAX(2048), .FRAC(FR)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .period_in       (period),
        .period_valid_in (period_valid),
        .sample_tick_in  (tick),
        .sample_out      (sample),
        .valid_out       (valid),
        .active_out      (active),
        .busy_out        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_sample(int per, int k);
        longint unsigned step;
        longint unsigned ph;
        int s;
        step = (64'd1 << AW) / longint'(per);
        ph   = longint'(k) * step;
        s    = int'(ph >> FR) % 65536;
`ifdef TAU_SYNTH_TRIANGLE_EN
        if (s < MID) return 2 * s;
        else return 65535 - 2 * (s - MID);
`else
        return s;
`endif
    endfunction

    task automatic model_reset();
        m_active = 0; m_per = 0; m_k = 0; m_pend = 0; m_pend_per = 0; m_mute = 0;
    endtask

    task automatic model_request(input int p);
        if (p < 2) begin
            m_mute = 1;
            m_pend = 0;
        end else if (!(m_active && p == m_per && !m_pend && !m_mute)) begin
            m_pend = 1;
            m_pend_per = p;
            m_mute = 0;
        end
    endtask

    task automatic model_settle();
        if (!m_active) begin
            m_mute = 0;
            if (m_pend) begin
                m_active = 1; m_per = m_pend_per; m_k = 0; m_pend = 0;
            end
        end
    endtask

    task automatic model_tick(output int e);
        if (!m_active) begin
            e = MID;
        end else begin
            e = ref_sample(m_per, m_k);
            if (m_k == m_per - 1) begin
                m_k = 0;
                if (m_mute) begin
                    m_active = 0; m_mute = 0;
                end else if (m_pend) begin
                    m_per = m_pend_per; m_pend = 0;
                end
            end else begin
                m_k++;
            end
        end
    endtask

    // All stimulus tasks start and end at a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_req(input int p);
        period = PWB'(p);
        period_valid = 1'b1;
        @(negedge clk);
        period_valid = 1'b0;
        model_request(p);
    endtask

    task automatic tick_once(output logic [W-1:0] s, output logic v);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        s = sample;
        v = valid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        period_valid = 1'b0;
        period = '0;
        idle(3);
        rst = 1'b0;
        model_reset();
        idle(1);
    endtask

    task automatic wait_settle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL settle: busy_out=%b, expected 0 within 100 cycles", busy);
        end
        idle(3);
        model_settle();
        checks++;
        if (active !== m_active) begin
            errors++;
            $display("FAIL settle_active: active_out=%b expected %b", active, m_active);
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] s;
        logic v;
        do_reset();
        checks++;
        if (sample !== 16'(MID) || valid !== 1'b0 || active !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: sample=%0d valid=%b active=%b busy=%b expected 32768 0 0 0",
                     sample, valid, active, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick_once(s, v);
            checks++;
            if (s !== 16'(MID) || v !== 1'b1 || active !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_tick%0d: sample=%0d valid=%b active=%b busy=%b expected 32768 1 0 0",
                         i, s, v, active, busy);
            end
            idle(1);
        end
    endtask

    task automatic test_period4();
        logic [W-1:0] s;
        logic v;
        int e;
        int nbusy;
        send_req(4);
        nbusy = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
        end
        checks++;
        if (nbusy != 27) begin
            errors++;
            $display("FAIL busy_cycles: busy_out high %0d cycles, expected 27", nbusy);
        end
        wait_settle();
        for (int i = 0; i < 8; i++) begin
            model_tick(e);
            tick_once(s, v);
            checks++;
            if (v !== 1'b1 || s !== 16'(e)) begin
                errors++;
                $display("FAIL p4_tick%0d: sample=%0d valid=%b expected %0d 1", i, s, v, e);
            end
            idle(1);
        end
    endtask

    task automatic test_period3();
        logic [W-1:0] s;
        logic v;
        int e;
        send_req(3);
        wait_settle();
        for (int i = 0; i < 10; i++) begin
            model_tick(e);
            tick_once(s, v);
            checks++;
            if (v !== 1'b1 || s !== 16'(e)) begin
                errors++;
                $display("FAIL p3_tick%0d: sample=%0d valid=%b expected %0d 1", i, s, v, e);
            end
        end
    endtask

    task automatic test_period_change();
        logic [W-1:0] s;
        logic v;
        int e;
        do_reset();
        send_req(4);
        wait_settle();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                send_req(2);
                wait_settle();
            end
            model_tick(e);
            tick_once(s, v);
            checks++;
            if (v !== 1'b1 || s !== 16'(e)) begin
                errors++;
                $display("FAIL change_tick%0d: sample=%0d valid=%b expected %0d 1", i, s, v, e);
            end
        end
    endtask

    task automatic test_mute();
        logic [W-1:0] s;
        logic v;
        int e;
        do_reset();
        send_req(4);
        wait_settle();
        for (int i = 0; i < 7; i++) begin
            if (i == 1) send_req(1);
            model_tick(e);
            tick_once(s, v);
            checks++;
            if (v !== 1'b1 || s !== 16'(e) || active !== m_active) begin
                errors++;
                $display("FAIL mute_tick%0d: sample=%0d active=%b expected %0d %b",
                         i, s, active, e, m_active);
            end
            idle(1);
        end
    endtask

    task automatic test_last_wins();
        logic [W-1:0] s;
        logic v;
        int e;
        do_reset();
        send_req(4);
        wait_settle();
        period = PWB'(5);
        period_valid = 1'b1;
        @(negedge clk);
        period = PWB'(6);
        @(negedge clk);
        period_valid = 1'b0;
        model_request(5);
        model_request(6);
        wait_settle();
        for (int i = 0; i < 16; i++) begin
            model_tick(e);
            tick_once(s, v);
            checks++;
            if (v !== 1'b1 || s !== 16'(e)) begin
                errors++;
                $display("FAIL last_wins_tick%0d: sample=%0d valid=%b expected %0d 1", i, s, v, e);
            end
            idle(1);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        tick = 1'b1;
        for (int i = 0; i < 14; i++) begin
            model_tick(e);
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || sample !== 16'(e)) begin
                errors++;
                $display("FAIL b2b_tick%0d: sample=%0d valid=%b expected %0d 1", i, sample, valid, e);
            end
        end
        tick = 1'b0;
        idle(1);
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        logic v;
        int e;
        int p;
        int nt;
        do_reset();
        for (int it = 0; it < 10; it++) begin
            if (it == 7) p = 2047;
            else p = int'($urandom_range(2, 40));
            send_req(p);
            wait_settle();
            nt = (p > 40) ? 20 : int'($urandom_range(1, 2 * p + 3));
            for (int i = 0; i < nt; i++) begin
                model_tick(e);
                tick_once(s, v);
                checks++;
                if (v !== 1'b1 || s !== 16'(e)) begin
                    errors++;
                    $display("FAIL rand%0d_tick%0d: sample=%0d valid=%b expected %0d 1 (period %0d)",
                             it, i, s, v, e, p);
                end
                idle(int'($urandom_range(0, 2)));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s;
        logic v;
        send_req(7);
        idle(5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_div_busy: busy_out=%b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || active !== 1'b0 || valid !== 1'b0 || sample !== 16'(MID)) begin
            errors++;
            $display("FAIL async_reset: busy=%b active=%b valid=%b sample=%0d expected 0 0 0 32768",
                     busy, active, valid, sample);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(40);
        checks++;
        if (busy !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b active=%b expected 0 0", busy, active);
        end
        tick_once(s, v);
        checks++;
        if (v !== 1'b1 || s !== 16'(MID)) begin
            errors++;
            $display("FAIL post_reset_tick: sample=%0d valid=%b expected 32768 1", s, v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        tick = 1'b0;
        period_valid = 1'b0;
        period = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_period4();
        test_period3();
        test_period_change();
        test_mute();
        test_last_wins();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
